muldiv_seq: RTL

- Multi-cycle sequencer for the M-extension datapath (unsigned MUL, MULHU, DIVU, REMU).
- Accepts one operation at a time from the execute stage over a valid/ready handshake.
- Multiply: fixed-latency registered product. Divide/remainder: iterative restoring divider, one quotient bit per cycle.
- Result is returned over a valid/ready handshake with the destination register tag; busy drives the pipeline stall.

---
 rtl/muldiv_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer: fixed-latency multiply and a
// restoring divider that retires one quotient bit per cycle, with valid/ready on both sides.
module muldiv_seq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      acl,
  input  logic [4:0]      rd_in,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            err,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [3:0] AclMul   = 4'b0000;
  localparam logic [3:0] AclMulhu = 4'b0001;
  localparam logic [3:0] AclDivu  = 4'b0100;
  localparam logic [3:0] AclRemu  = 4'b0110;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]      acl_q, acl_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d;

  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem_sh, trial;
  logic [XLEN-1:0]   rem_nx, quo_nx;

  always_comb begin
    prod = (2*XLEN)'(a_q) * (2*XLEN)'(b_q);

    // Shift {rem, quo} left by one; a negative 33-bit trial means restore.
    rem_sh = {rem_q, quo_q[XLEN-1]};
    trial  = rem_sh - {1'b0, b_q};
    rem_nx = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ~trial[XLEN]};

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acl_d    = acl_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = err_q;
    rem_d    = rem_q;
    quo_d    = quo_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d   = a;
          b_d   = b;
          acl_d = acl;
          rd_d  = rd_in;
          err_d = 1'b0;
          case (acl)
            AclMul, AclMulhu: begin
              state_d = StMul;
              cnt_d   = CntW'(MUL_LAT - 1);
            end
            AclDivu, AclRemu: begin
              if (b == '0) begin
                state_d  = StDone;
                result_d = (acl == AclDivu) ? '1 : a;
              end else begin
                state_d = StDiv;
                cnt_d   = CntW'(XLEN - 1);
                rem_d   = '0;
                quo_d   = a;
              end
            end
            default: begin
              state_d  = StDone;
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          result_d = (acl_q == AclMulhu) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) begin
          result_d = (acl_q == AclRemu) ? rem_nx : quo_nx;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    resp_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acl_q        <= '0;
      rd_q         <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acl_q        <= acl_d;
      rd_q         <= rd_d;
      result_q     <= result_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = ~req_ready;
  assign resp_valid = resp_valid_q;
  assign result     = result_q;
  assign rd_out     = rd_q;
  assign err        = err_q;

endmodule
